// File: rtl/avmm_arb_pkg.sv
// Shared types and default sizes for the Avalon-MM data-port arbiter.
package avmm_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, RDATA} state_e;
  typedef enum logic {REQ_IF = 1'b0, REQ_LS = 1'b1} req_e;

  localparam int unsigned ADDR_W_DEF    = 19;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned BURST_W_DEF   = 4;
  localparam int unsigned MAX_BURST_DEF = 8;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant decision; remembers the last winner.
module rr_arbiter_2
  import avmm_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_if_i,
  input  logic req_ls_i,
  input  logic take_i,
  output req_e gnt_o,
  output logic any_o
);

  req_e last_q, last_d;

  assign any_o = req_if_i | req_ls_i;

  always_comb begin
    gnt_o = REQ_IF;
    if (req_if_i && req_ls_i) begin
      gnt_o = (last_q == REQ_IF) ? REQ_LS : REQ_IF;
    end else if (req_ls_i) begin
      gnt_o = REQ_LS;
    end
    last_d = last_q;
    if (take_i && any_o) last_d = gnt_o;
  end

  // LS as the reset winner lets IF take the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= REQ_LS;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/avmm_data_arbiter.sv
// Shares the memory Avalon-MM data port between instruction fetch and load/store.
module avmm_data_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_W   = BURST_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               if_read,
  input  logic [BURST_W-1:0] if_burstcount,
  output logic [DATA_W-1:0]  if_readdata,
  output logic               if_readdatavalid,
  output logic               if_waitrequest,
  input  logic [ADDR_W-1:0]  ls_addr,
  input  logic               ls_read,
  input  logic               ls_write,
  input  logic [DATA_W-1:0]  ls_writedata,
  input  logic [BURST_W-1:0] ls_burstcount,
  output logic [DATA_W-1:0]  ls_readdata,
  output logic               ls_readdatavalid,
  output logic               ls_waitrequest,
  output logic [ADDR_W-1:0]  avmm_data_addr,
  output logic               avmm_data_read,
  output logic               avmm_data_write,
  output logic [DATA_W-1:0]  avmm_data_writedata,
  output logic [BURST_W-1:0] avmm_data_burstcount,
  input  logic [DATA_W-1:0]  avmm_data_readdata,
  input  logic               avmm_data_waitrequest,
  input  logic               avmm_data_readdatavalid,
  output logic               protocol_error
);

  state_e             state_q, state_d;
  req_e               owner_q, owner_d, gnt;
  logic [BURST_W-1:0] beats_q, beats_d;
  logic               perr_q, perr_d;
  logic               any_req, take;

  logic [BURST_W-1:0] g_bc, o_bc;
  logic [ADDR_W-1:0]  o_addr;
  logic               o_rd, o_wr;

  function automatic logic [BURST_W-1:0] eff_bc(input logic [BURST_W-1:0] bc);
    if (bc == '0) return BURST_W'(1);
    if (32'(bc) > MAX_BURST) return BURST_W'(MAX_BURST);
    return bc;
  endfunction

  rr_arbiter_2 u_rr (
    .clk_i   (clock),
    .rst_i   (reset),
    .req_if_i(if_read),
    .req_ls_i(ls_read | ls_write),
    .take_i  (take),
    .gnt_o   (gnt),
    .any_o   (any_req)
  );

  assign g_bc   = (gnt == REQ_IF) ? if_burstcount : ls_burstcount;
  assign o_bc   = (owner_q == REQ_IF) ? if_burstcount : ls_burstcount;
  assign o_addr = (owner_q == REQ_IF) ? if_addr : ls_addr;
  assign o_wr   = (owner_q == REQ_LS) & ls_write;
  // A simultaneous LS read+write is carried out as a write.
  assign o_rd   = ((owner_q == REQ_IF) ? if_read : ls_read) & ~o_wr;

  assign protocol_error = perr_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beats_d = beats_q;
    perr_d  = perr_q;
    take    = 1'b0;
    avmm_data_addr       = '0;
    avmm_data_read       = 1'b0;
    avmm_data_write      = 1'b0;
    avmm_data_writedata  = '0;
    avmm_data_burstcount = '0;
    if_waitrequest       = 1'b1;
    ls_waitrequest       = 1'b1;
    if_readdatavalid     = 1'b0;
    ls_readdatavalid     = 1'b0;
    if_readdata          = avmm_data_readdata;
    ls_readdata          = avmm_data_readdata;
    unique case (state_q)
      IDLE: begin
        if (avmm_data_readdatavalid) perr_d = 1'b1;
        if (any_req) begin
          take    = 1'b1;
          owner_d = gnt;
          beats_d = eff_bc(g_bc);
          if (32'(g_bc) > MAX_BURST) perr_d = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (avmm_data_readdatavalid) perr_d = 1'b1;
        if (o_rd || o_wr) begin
          avmm_data_addr       = o_addr;
          avmm_data_read       = o_rd;
          avmm_data_write      = o_wr;
          avmm_data_writedata  = o_wr ? ls_writedata : '0;
          avmm_data_burstcount = eff_bc(o_bc);
          if (owner_q == REQ_IF) if_waitrequest = avmm_data_waitrequest;
          else                   ls_waitrequest = avmm_data_waitrequest;
          if (owner_q == REQ_LS && ls_read && ls_write) perr_d = 1'b1;
          if (!avmm_data_waitrequest) begin
            if (o_wr) begin
              beats_d = beats_q - BURST_W'(1);
              if (beats_q == BURST_W'(1)) state_d = IDLE;
            end else begin
              state_d = RDATA;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RDATA: begin
        if (avmm_data_readdatavalid) begin
          if (owner_q == REQ_IF) if_readdatavalid = 1'b1;
          else                   ls_readdatavalid = 1'b1;
          beats_d = beats_q - BURST_W'(1);
          if (beats_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= REQ_IF;
      beats_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_avmm_data_arbiter.sv
// Randomized bench: bus-functional masters, a memory model and transaction-level expectations.
module tb_avmm_data_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [18:0] if_addr, ls_addr, avmm_data_addr;
  logic        if_read, ls_read, ls_write;
  logic [3:0]  if_burstcount, ls_burstcount, avmm_data_burstcount;
  logic [31:0] if_readdata, ls_readdata, ls_writedata, avmm_data_writedata, avmm_data_readdata;
  logic        if_readdatavalid, if_waitrequest, ls_readdatavalid, ls_waitrequest;
  logic        avmm_data_read, avmm_data_write, avmm_data_waitrequest, avmm_data_readdatavalid;
  logic        protocol_error;

  int n_vec = 0, n_err = 0;
  int last_g;                       // 0 = IF, 1 = LS
  int lat = 0, stall_left = 0, stall_at = 0, wr_cnt = 0;
  bit rand_wait = 0, mirror_on = 0;
  logic [31:0] rdq[$], if_rx[$], ls_rx[$], if_exp[$], ls_exp[$];
  logic [50:0] wr_log[$], wr_exp[$];
  logic [3:0]  bc_log[$];
  int          grant_log[$];

  always #5 clock = ~clock;

  avmm_data_arbiter #(.ADDR_W(19), .DATA_W(32), .BURST_W(4), .MAX_BURST(8)) dut (
    .clock(clock), .reset(reset),
    .if_addr(if_addr), .if_read(if_read), .if_burstcount(if_burstcount),
    .if_readdata(if_readdata), .if_readdatavalid(if_readdatavalid), .if_waitrequest(if_waitrequest),
    .ls_addr(ls_addr), .ls_read(ls_read), .ls_write(ls_write), .ls_writedata(ls_writedata),
    .ls_burstcount(ls_burstcount), .ls_readdata(ls_readdata), .ls_readdatavalid(ls_readdatavalid),
    .ls_waitrequest(ls_waitrequest),
    .avmm_data_addr(avmm_data_addr), .avmm_data_read(avmm_data_read), .avmm_data_write(avmm_data_write),
    .avmm_data_writedata(avmm_data_writedata), .avmm_data_burstcount(avmm_data_burstcount),
    .avmm_data_readdata(avmm_data_readdata), .avmm_data_waitrequest(avmm_data_waitrequest),
    .avmm_data_readdatavalid(avmm_data_readdatavalid), .protocol_error(protocol_error)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [18:0] a, input int i);
    if (a == 19'h10 && i == 0) return 32'hDEADBEEF;
    return {13'h0A5, a} + 32'(i) * 32'h01010101;
  endfunction

  function automatic int eff(input logic [3:0] bc);
    if (bc == 0) return 1;
    if (bc > 8) return 8;
    return int'(bc);
  endfunction

  // Memory slave: accepts commands, returns read beats after a short latency.
  always @(posedge clock) begin
    #1;
    if (rdq.size() > 0 && lat == 0) begin
      avmm_data_readdatavalid = 1'b1;
      avmm_data_readdata      = rdq.pop_front();
    end else begin
      avmm_data_readdatavalid = 1'b0;
      avmm_data_readdata      = $urandom;
      if (lat > 0) lat--;
    end
    if (stall_left > 0) begin
      avmm_data_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avmm_data_waitrequest = rand_wait && ($urandom_range(0, 3) == 0);
    end
  end

  always @(negedge clock) begin
    int nb;
    if (avmm_data_read && !avmm_data_waitrequest) begin
      bc_log.push_back(avmm_data_burstcount);
      nb = (avmm_data_burstcount == 0) ? 1 : int'(avmm_data_burstcount);
      for (int i = 0; i < nb; i++) rdq.push_back(mem_word(avmm_data_addr, i));
      lat = 2;
    end
    if (avmm_data_write && !avmm_data_waitrequest) begin
      wr_log.push_back({avmm_data_addr, avmm_data_writedata});
      wr_cnt++;
      if (wr_cnt == stall_at) stall_left = 2;
    end
    if (if_readdatavalid) if_rx.push_back(if_readdata);
    if (ls_readdatavalid) ls_rx.push_back(ls_readdata);
    if (if_readdatavalid || ls_readdatavalid)
      chk("dual_rdv", if_readdatavalid & ls_readdatavalid, 0);
    if (mirror_on) begin
      chk("if_wait_hold", if_waitrequest, 1);
      if (avmm_data_write) chk("ls_wait_mirror", ls_waitrequest, avmm_data_waitrequest);
    end
  end

  task automatic if_txn(input logic [18:0] a, input logic [3:0] bc);
    int n = 0;
    if_addr = a; if_burstcount = bc; if_read = 1'b1;
    do begin @(negedge clock); n++; end while (if_waitrequest && n < 200);
    chk("if_accept", if_waitrequest, 0);
    grant_log.push_back(0);
    for (int i = 0; i < eff(bc); i++) if_exp.push_back(mem_word(a, i));
    @(posedge clock); #1;
    if_read = 1'b0;
  endtask

  task automatic ls_txn(input logic [18:0] a, input logic [3:0] bc, input bit wr, input logic [31:0] d0);
    int n;
    ls_addr = a; ls_burstcount = bc;
    for (int i = 0; i < (wr ? eff(bc) : 1); i++) begin
      ls_write = wr; ls_read = !wr; ls_writedata = d0 + 32'(i);
      n = 0;
      do begin @(negedge clock); n++; end while (ls_waitrequest && n < 200);
      chk("ls_accept", ls_waitrequest, 0);
      if (i == 0) grant_log.push_back(1);
      if (wr) wr_exp.push_back({a, d0 + 32'(i)});
      @(posedge clock); #1;
    end
    if (!wr) for (int i = 0; i < eff(bc); i++) ls_exp.push_back(mem_word(a, i));
    ls_write = 1'b0; ls_read = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (rdq.size() != 0 && n < 500) begin @(posedge clock); n++; end
    chk("drain", rdq.size(), 0);
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, "_if_cnt"}, if_rx.size(), if_exp.size());
    for (int i = 0; i < if_rx.size() && i < if_exp.size(); i++) chk({tag, "_if_data"}, if_rx[i], if_exp[i]);
    chk({tag, "_ls_cnt"}, ls_rx.size(), ls_exp.size());
    for (int i = 0; i < ls_rx.size() && i < ls_exp.size(); i++) chk({tag, "_ls_data"}, ls_rx[i], ls_exp[i]);
    chk({tag, "_wr_cnt"}, wr_log.size(), wr_exp.size());
    for (int i = 0; i < wr_log.size() && i < wr_exp.size(); i++) chk({tag, "_wr"}, wr_log[i], wr_exp[i]);
    if_rx.delete(); if_exp.delete(); ls_rx.delete(); ls_exp.delete(); wr_log.delete(); wr_exp.delete();
  endtask

  // Round-robin model: each grant alternates starting from the given requester.
  task automatic check_grants(input string tag, input int first, input int n);
    int e = first;
    chk({tag, "_n"}, grant_log.size(), n);
    foreach (grant_log[i]) begin
      chk(tag, grant_log[i], e);
      e = 1 - e;
    end
    if (grant_log.size() > 0) last_g = grant_log[$];
    grant_log.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd"}, avmm_data_read, 0);
    chk({tag, "_wr"}, avmm_data_write, 0);
    chk({tag, "_addr"}, avmm_data_addr, 0);
    chk({tag, "_bc"}, avmm_data_burstcount, 0);
    chk({tag, "_wd"}, avmm_data_writedata, 0);
    chk({tag, "_if_wait"}, if_waitrequest, 1);
    chk({tag, "_ls_wait"}, ls_waitrequest, 1);
    chk({tag, "_if_rdv"}, if_readdatavalid, 0);
    chk({tag, "_ls_rdv"}, ls_readdatavalid, 0);
    chk({tag, "_perr"}, protocol_error, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; last_g = 1;
    if_addr = '0; if_read = 0; if_burstcount = '0;
    ls_addr = '0; ls_read = 0; ls_write = 0; ls_writedata = '0; ls_burstcount = '0;
    avmm_data_waitrequest = 0; avmm_data_readdatavalid = 0; avmm_data_readdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outs("rst0");
    @(posedge clock); #1;
    reset = 1'b0;

    // IF single read of the DEADBEEF word
    if_addr = 19'h10; if_burstcount = 4'd1; if_read = 1'b1;
    @(negedge clock);
    chk("t1_arb_cycle_rd", avmm_data_read, 0);
    @(negedge clock);
    chk("t1_cmd_rd", avmm_data_read, 1);
    chk("t1_cmd_addr", avmm_data_addr, 19'h10);
    chk("t1_cmd_bc", avmm_data_burstcount, 1);
    chk("t1_if_wait", if_waitrequest, 0);
    chk("t1_ls_wait", ls_waitrequest, 1);
    @(posedge clock); #1;
    if_read = 1'b0;
    grant_log.push_back(0);
    if_exp.push_back(32'hDEADBEEF);
    drain();
    cmp_all("t1");
    check_grants("t1_grant", 0, 1);
    chk("t1_idle_wait", if_waitrequest, 1);

    // LS write burst with a 2-cycle stall on beat 2
    stall_at = 1; wr_cnt = 0; mirror_on = 1;
    ls_txn(19'h100, 4'd4, 1'b1, 32'd1);
    mirror_on = 0; stall_at = 0;
    drain();
    cmp_all("t2");
    check_grants("t2_grant", 1, 1);

    // Both masters continuously requesting: IF bursts of 8, LS singles
    fork
      for (int k = 0; k < 3; k++) if_txn(19'($urandom), 4'd8);
      for (int k = 0; k < 3; k++) ls_txn(19'($urandom), 4'd1, 1'b0, 32'd0);
    join
    drain();
    cmp_all("t3");
    check_grants("t3_grant", 1 - last_g, 6);

    // Random mix with random memory stalls
    rand_wait = 1;
    fork
      for (int k = 0; k < 6; k++) if_txn(19'($urandom), 4'($urandom_range(0, 8)));
      for (int k = 0; k < 6; k++)
        ls_txn(19'($urandom), 4'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), $urandom);
    join
    drain();
    rand_wait = 0;
    cmp_all("rnd");
    check_grants("rnd_grant", 1 - last_g, 12);

    // burstcount 0 behaves as a single beat
    if_txn(19'($urandom), 4'd0);
    drain();
    cmp_all("bc0");
    check_grants("bc0_grant", 0, 1);
    chk("bc0_idle_wait", if_waitrequest, 1);
    chk("perr_clean", protocol_error, 0);

    // Oversized burst is clamped and flagged
    bc_log.delete();
    ls_txn(19'($urandom), 4'd12, 1'b0, 32'd0);
    drain();
    chk("bc12_avmm_bc", bc_log.size() > 0 ? bc_log[$] : 4'hF, 8);
    cmp_all("bc12");
    chk("bc12_perr", protocol_error, 1);
    if_txn(19'($urandom), 4'd2);
    drain();
    cmp_all("post12");
    chk("perr_sticky", protocol_error, 1);
    check_grants("bc12_grant", 1, 2);

    // Reset in the middle of an 8-beat read
    if_txn(19'($urandom), 4'd8);
    n = 0;
    do begin @(negedge clock); #1; n++; end while (if_rx.size() < 3 && n < 200);
    chk("mid_beats", if_rx.size(), 3);
    reset = 1'b1;
    last_g = 1;
    @(negedge clock);
    chk_reset_outs("rst1");
    @(negedge clock);
    chk("rst2_if_rdv", if_readdatavalid, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    drain();
    chk("rst_no_more_beats", if_rx.size(), 3);
    chk("stray_perr", protocol_error, 1);
    if_rx.delete(); if_exp.delete(); grant_log.delete();
    fork
      if_txn(19'($urandom), 4'd1);
      ls_txn(19'($urandom), 4'd1, 1'b0, 32'd0);
    join
    drain();
    cmp_all("post_rst");
    check_grants("post_rst_grant", 1 - last_g, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avmm_data_arbiter.md
Name: avmm_data_arbiter

Overview:
- Shares the single Avalon-MM data port of the core's memory interface between two requesters: instruction fetch (IF, read-only) and load/store (LS, read and write).
- Each requester sees an Avalon-MM slave port. The arbiter acts as the sole master on the memory data port.
- Round-robin arbitration. Exactly one transaction (including its whole burst) owns the port at a time.
- Sits between the core pipeline and the memory interface.

Parameters:
- ADDR_W, 19, word address width.
- DATA_W, 32, data width.
- BURST_W, 4, burstcount width.
- MAX_BURST, 8, largest legal burstcount.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_addr  in  ADDR_W  IF read address.
- if_read  in  1  IF read request.
- if_burstcount  in  BURST_W  IF burst length.
- if_readdata  out  DATA_W  IF read data.
- if_readdatavalid  out  1  IF read beat valid.
- if_waitrequest  out  1  IF command stall.
- ls_addr  in  ADDR_W  LS address.
- ls_read  in  1  LS read request.
- ls_write  in  1  LS write request.
- ls_writedata  in  DATA_W  LS write data.
- ls_burstcount  in  BURST_W  LS burst length.
- ls_readdata  out  DATA_W  LS read data.
- ls_readdatavalid  out  1  LS read beat valid.
- ls_waitrequest  out  1  LS command/beat stall.
- avmm_data_addr  out  ADDR_W  to memory interface.
- avmm_data_read  out  1  to memory interface.
- avmm_data_write  out  1  to memory interface.
- avmm_data_writedata  out  DATA_W  to memory interface.
- avmm_data_burstcount  out  BURST_W  to memory interface.
- avmm_data_readdata  in  DATA_W  from memory interface.
- avmm_data_waitrequest  in  1  from memory interface.
- avmm_data_readdatavalid  in  1  from memory interface.
- protocol_error  out  1  sticky flag for illegal burstcount.

Behaviour:
- Reset values:
  - state=IDLE; owner=none; beat counter=0; last_grant=LS (so IF wins the first tie); protocol_error=0.
  - All avmm_data_* outputs = 0.
  - if_waitrequest = ls_waitrequest = 1; both readdatavalid = 0.
- States: IDLE, CMD, RDATA.
- IDLE:
  - Both waitrequests = 1; avmm outputs = 0.
  - Request = IF: if_read. Request = LS: ls_read | ls_write.
  - One requester active: register it as owner.
  - Both active: owner = the one not equal to last_grant.
  - Then last_grant <= owner; beats <= burstcount (0 is treated as 1); go to CMD.
  - Arbitration costs exactly 1 cycle.
- CMD:
  - avmm_data_addr/read/write/writedata/burstcount are driven combinationally from the owner; the write strobe is forced 0 for IF.
  - Owner waitrequest = avmm_data_waitrequest. Non-owner waitrequest = 1.
  - Read accepted (read & !avmm_data_waitrequest): go to RDATA.
  - Write beat accepted: beats <= beats-1. If beats==1, go to IDLE; otherwise stay in CMD (addr/burstcount held by the requester per Avalon).
  - Owner deasserts both read and write before acceptance: go to IDLE and drive nothing.
- RDATA:
  - avmm read/write = 0; both waitrequests = 1.
  - avmm_data_readdata fans out combinationally to both readdata ports.
  - Only the owner's readdatavalid follows avmm_data_readdatavalid.
  - Each valid beat decrements beats. The last beat (beats==1) returns to IDLE in the next cycle.
- Back-to-back: after the last read beat or write beat, the next grant is issued in IDLE (1 idle cycle between transactions).
- Fairness: with both requesters continuously requesting, grants strictly alternate IF, LS, IF, LS. No requester waits more than one transaction.
- burstcount > MAX_BURST on a requester that is granted:
  - Set protocol_error (sticky until reset).
  - Clamp the beat counter and avmm_data_burstcount to MAX_BURST.
- ls_read & ls_write both high: treat as a write and set protocol_error.
- readdatavalid while in IDLE/CMD (stray beat): dropped, routed to neither requester. Set protocol_error.
- Reset mid-transaction: state returns to IDLE immediately; outstanding beats are dropped. The memory interface shares this reset.

Decomposition:
- Package avmm_arb_pkg holds:
  - state enum {IDLE, CMD, RDATA}.
  - requester ID enum {REQ_IF, REQ_LS}.
  - MAX_BURST default and width constants.
- Sub-module rr_arbiter_2: 2-input round-robin pick with a registered last_grant. Purely the grant decision.
- Muxing, beat counting and the FSM stay in the top module.

Test Plan:
- IF single read to addr 0x00010, burstcount 1, memory returns 0xDEADBEEF 3 cycles after accept.
  - Required: avmm_data_read high 1 cycle after if_read; if_readdatavalid for one cycle with 0xDEADBEEF; ls_readdatavalid stays 0; return to IDLE.
- LS write burst of 4 to 0x00100, data 1..4, memory waitrequest high 2 cycles on beat 2.
  - Required: exactly 4 avmm writes in order 1..4; ls_waitrequest mirrors the stall; if_waitrequest=1 throughout.
- Both request every cycle, IF burst 8 reads, LS single reads, for 6 transactions.
  - Required: grant order IF, LS, IF, LS, IF, LS; each IF gets 8 valid beats; no beat is misrouted.
- Reset asserted during RDATA after 3 of 8 beats.
  - Required: next cycle all outputs at reset values; remaining beats produce no readdatavalid; next grant goes to IF.
- LS read with burstcount 12.
  - Required: avmm_data_burstcount=8; 8 beats are delivered; protocol_error=1 and stays 1 until reset.
- IF burstcount 0 read.
  - Required: treated as 1 beat; return to IDLE after the single readdatavalid.
